// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch front end.
// Owns the PC and issues in-order word fetches to instruction memory. Returned
// instructions are buffered for decode. A redirect from execute flushes all
// wrong-path state and restarts fetch at the new target.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req_valid/ready/addr fetch request channel (addr word aligned)
//   imem_rsp_valid/data       in-order responses, no backpressure
//   if_valid/ready/pc/instr   instruction handoff to decode
//   redirect_valid/target     taken branch/jump from execute
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
);

  localparam int unsigned PW = $clog2(DEPTH);      // queue pointer width
  localparam int unsigned CW = $clog2(DEPTH + 1);  // count width, 0..DEPTH
  localparam int unsigned OW = CW + 1;             // inflight + ob_count

  logic [31:0]   r_pc;
  logic [31:0]   r_aq [DEPTH];
  logic [PW-1:0] r_aq_wp;
  logic [PW-1:0] r_aq_rp;
  logic [31:0]   r_ob_pc [DEPTH];
  logic [31:0]   r_ob_instr [DEPTH];
  logic [PW-1:0] r_ob_wp;
  logic [PW-1:0] r_ob_rp;
  logic [CW-1:0] r_ob_cnt;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop_cnt;

  logic [OW-1:0] w_occ;
  logic          w_has_room;
  logic          w_ob_empty;
  logic          w_issue;
  logic          w_drop;
  logic          w_keep;
  logic          w_pop;

  // Stale in-flight requests still occupy capacity, so the buffer can never
  // overflow even when responses return back to back.
  assign w_occ      = OW'(r_inflight) + OW'(r_ob_cnt);
  assign w_has_room = w_occ < OW'(DEPTH);
  assign w_ob_empty = (r_ob_cnt == '0);

  assign imem_req_valid = !rst && !redirect_valid && w_has_room;
  assign imem_req_addr  = r_pc;

  assign if_valid = !rst && !w_ob_empty && !redirect_valid;
  assign if_pc    = w_ob_empty ? 32'h0 : r_ob_pc[r_ob_rp];
  assign if_instr = w_ob_empty ? 32'h0 : r_ob_instr[r_ob_rp];

  assign w_issue = imem_req_valid && imem_req_ready;
  assign w_drop  = imem_rsp_valid && (r_drop_cnt != '0);
  // A response landing in a redirect cycle belongs to the wrong path.
  assign w_keep  = !rst && imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
  assign w_pop   = if_valid && if_ready;

  // Control state: PC, queue pointers and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_aq_wp    <= '0;
      r_aq_rp    <= '0;
      r_ob_wp    <= '0;
      r_ob_rp    <= '0;
      r_ob_cnt   <= '0;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      r_pc       <= {redirect_target[31:2], 2'b00};
      r_aq_wp    <= '0;
      r_aq_rp    <= '0;
      r_ob_wp    <= '0;
      r_ob_rp    <= '0;
      r_ob_cnt   <= '0;
      // Everything still outstanding after this cycle is wrong-path.
      r_inflight <= r_inflight - CW'(imem_rsp_valid);
      r_drop_cnt <= r_inflight - CW'(imem_rsp_valid);
    end else begin
      if (w_issue) begin
        r_pc    <= r_pc + 32'd4;
        r_aq_wp <= r_aq_wp + PW'(1);
      end
      if (w_keep) begin
        r_aq_rp <= r_aq_rp + PW'(1);
        r_ob_wp <= r_ob_wp + PW'(1);
      end
      if (w_pop) begin
        r_ob_rp <= r_ob_rp + PW'(1);
      end
      r_ob_cnt   <= r_ob_cnt + CW'(w_keep) - CW'(w_pop);
      r_inflight <= r_inflight + CW'(w_issue) - CW'(imem_rsp_valid);
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  // Queue storage; contents are only meaningful under the pointers above.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_aq[r_aq_wp] <= r_pc;
    end
    if (w_keep) begin
      r_ob_pc[r_ob_wp]    <= r_aq[r_aq_rp];
      r_ob_instr[r_ob_wp] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit with an in-order
// variable-latency memory model and a PC-stream reference model.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mreq_t       mq[$];   // memory: accepted requests awaiting response
  exp_t        sb[$];   // expected correct-path deliveries, in order
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          epoch = 0;
  int          arrived = 0;   // correct-path responses returned, not yet delivered
  int          delivered = 0;
  int          rsp_epoch = 0;
  logic [31:0] ref_pc = RESET_PC;

  int lat_min = 1, lat_max = 1, rdy_pct = 100, ifr_pct = 100, redir_pm = 0;
  bit redir_on_rsp = 1'b0;
  bit force_redir = 1'b0;
  logic [31:0] force_tgt = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endfunction

  // Drive one cycle of inputs just after the rising edge.
  task automatic step();
    logic [31:0] t;
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      rsp_epoch      = mq[0].epoch;
      void'(mq.pop_front());
    end
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    if_ready       = ($urandom_range(99) < ifr_pct);
    t = $urandom;
    if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
    redirect_valid  = !rst && ($urandom_range(999) < redir_pm);
    redirect_target = t;
    if (force_redir && !rst) begin
      redirect_valid  = 1'b1;
      redirect_target = force_tgt;
      force_redir     = 1'b0;
    end
    if (redir_on_rsp && imem_rsp_valid) begin
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0203;
      redir_on_rsp    = 1'b0;
    end
  endtask

  // Monitor/scoreboard: observes the settled cycle before the next edge.
  always @(negedge clk) begin : monitor
    int    infl;
    bit    exp_ifv;
    bit    exp_rqv;
    exp_t  e;
    mreq_t m;
    if (rst) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_if_valid", 32'(if_valid), 32'h0);
      mq.delete();
      sb.delete();
      arrived = 0;
      epoch++;
      ref_pc = RESET_PC;
    end else begin
      infl    = mq.size() + (imem_rsp_valid ? 1 : 0);
      chk("occupancy_le_depth", 32'(infl + arrived <= DEPTH), 32'h1);
      exp_ifv = (arrived > 0) && !redirect_valid;
      exp_rqv = !redirect_valid && (infl + arrived < DEPTH);
      chk("if_valid", 32'(if_valid), 32'(exp_ifv));
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rqv));
      if (arrived == 0) begin
        chk("if_pc_empty", if_pc, 32'h0);
        chk("if_instr_empty", if_instr, 32'h0);
      end
      if (if_valid && if_ready) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_delivery cyc=%0d actual pc=%h expected none", cyc, if_pc);
        end else begin
          e = sb.pop_front();
          chk("if_pc", if_pc, e.pc);
          chk("if_instr", if_instr, e.instr);
          delivered++;
          if (arrived > 0) arrived--;
        end
      end
      if (imem_rsp_valid && rsp_epoch == epoch && !redirect_valid) arrived++;
      if (redirect_valid) begin
        sb.delete();
        arrived = 0;
        epoch++;
        ref_pc = {redirect_target[31:2], 2'b00};
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, ref_pc);
        m.addr  = imem_req_addr;
        m.due   = cyc + int'($urandom_range(lat_max, lat_min));
        m.epoch = epoch;
        mq.push_back(m);
        e.pc    = ref_pc;
        e.instr = mem_word(ref_pc);
        sb.push_back(e);
        ref_pc  = ref_pc + 32'd4;
      end
    end
  end

  initial begin
    int d0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Steady streaming, 1-cycle memory, decode always ready.
    d0 = delivered;
    repeat (30) step();
    chk("steady_progress", 32'(delivered - d0 >= 15), 32'h1);

    // Decode stall: buffer fills and requests stop.
    ifr_pct = 0;
    repeat (10) step();
    #1;
    chk("stall_if_valid", 32'(if_valid), 32'h1);
    chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
    ifr_pct = 100;
    repeat (10) step();

    // Redirect with two requests in flight.
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 50 && mq.size() < 2; i++) step();
    chk("two_inflight_reached", 32'(mq.size() >= 2), 32'h1);
    force_redir = 1'b1;
    force_tgt   = 32'h0000_0100;
    step();
    repeat (15) step();

    // Redirect coinciding with a response; unaligned target.
    lat_min = 1;
    lat_max = 1;
    redir_on_rsp = 1'b1;
    for (int i = 0; i < 50 && redir_on_rsp; i++) step();
    chk("redir_on_rsp_done", 32'(redir_on_rsp), 32'h0);
    repeat (10) step();

    // Random traffic: ready toggling, latency 1-3, random redirects.
    lat_min  = 1;
    lat_max  = 3;
    rdy_pct  = 60;
    ifr_pct  = 70;
    redir_pm = 60;
    d0 = delivered;
    for (int i = 0; i < 6000 && (delivered - d0) < 200; i++) step();
    chk("random_progress", 32'(delivered - d0 >= 200), 32'h1);

    // Reset with the buffer full.
    redir_pm = 0;
    rdy_pct  = 100;
    ifr_pct  = 0;
    lat_min  = 1;
    lat_max  = 1;
    for (int i = 0; i < 30 && arrived < DEPTH; i++) step();
    chk("ob_full_before_rst", 32'(if_valid && !imem_req_valid), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ifr_pct = 100;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
